sweep_sequencer: RTL
====================

SWEEP_SEQUENCER -- requirements
Module: sweep_sequencer

Interface
REQ-001 SHALL have parameter N_SAMPLES, default 1024, samples captured per chirp (power of 2, 2..65536).
REQ-002 SHALL have parameter N_SETTLE, default 64, decimated samples discarded after ramp start (0..65535).
REQ-003 SHALL have parameter CNT_W, default 16, width of chirp_cnt.
REQ-004 clk  input  1  system clock, all logic rising-edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 start  input  1  pulse; begin continuous chirping.
REQ-007 stop  input  1  pulse; finish current chirp, then idle.
REQ-008 adf_done  input  1  level; synthesizer configured and locked.
REQ-009 fir_valid  input  1  decimated-sample strobe.
REQ-010 host_ready  input  1  level; host link can accept one frame.
REQ-011 fft_done  input  1  pulse; FFT finished emitting frame.
REQ-012 adf_en, fir_en, fifo_wren, fifo_rden, fft_en  output  1 each  datapath enables.
REQ-013 ramp_trig  output  1  one-cycle ramp start pulse.
REQ-014 fifo_clr  output  1  one-cycle FIFO flush pulse.
REQ-015 busy  output  1  high in any state except IDLE.
REQ-016 lock_err  output  1  sticky lock-loss flag.
REQ-017 chirp_cnt  output  CNT_W  completed-chirp count.

Function
REQ-018 States SHALL be IDLE, CONFIG, SETTLE, CAPTURE, WAIT_HOST, READ, DRAIN.
REQ-019 IDLE: all enables 0; start -> CONFIG, clears lock_err and stop_pending; start and stop same cycle -> start wins, stop_pending set.
REQ-020 CONFIG: adf_en=1; adf_done=1 -> SETTLE (or CAPTURE if N_SETTLE=0), ramp_trig=1 registered, high first cycle of next state only.
REQ-021 SETTLE: adf_en=fir_en=1, fifo_wren=0; count fir_valid; after N_SETTLE strobes -> CAPTURE, counter reset to 0.
REQ-022 CAPTURE: adf_en=fir_en=1, fifo_wren=fir_valid (combinational); after exactly N_SAMPLES writes -> WAIT_HOST.
REQ-023 adf_done low in SETTLE or CAPTURE: lock_err<=1, fifo_clr pulse one cycle, counter reset, -> CONFIG (or IDLE if stop_pending); chirp_cnt unchanged.
REQ-024 WAIT_HOST: all enables 0; host_ready=1 -> READ.
REQ-025 READ: fifo_rden=1 exactly N_SAMPLES consecutive cycles; fft_en=fifo_rden delayed one cycle (FIFO read latency 1), so fft_en high N_SAMPLES cycles, last in first DRAIN cycle.
REQ-026 DRAIN: fifo_rden=0; wait fft_done; fft_done outside DRAIN SHALL be ignored.
REQ-027 On fft_done in DRAIN: chirp_cnt+1 modulo 2^CNT_W; -> IDLE if stop_pending (or stop same cycle) else CONFIG.
REQ-028 stop in any non-IDLE state SHALL set stop_pending; stop in IDLE ignored; start when busy ignored.
REQ-029 host_ready dropping during READ/DRAIN SHALL NOT interrupt the frame.
REQ-030 Sample counter width SHALL be clog2(max(N_SAMPLES,N_SETTLE))+1; no wrap within a phase.

Reset
REQ-031 rst_n=0 SHALL force IDLE, counters 0, chirp_cnt 0, lock_err 0, stop_pending 0, fft_en delay reg 0.
REQ-032 All outputs SHALL be 0 during and first cycle after reset; reset mid-READ truncates frame without fifo_clr.

Structure
REQ-033 State enum, default N_SAMPLES/N_SETTLE, CNT_W SHALL live in shared package fmcw_pkg.
REQ-034 One sub-module SHALL be natural: seq_counter (load-zero, enable, terminal-count compare) used for SETTLE, CAPTURE, READ.

Verification
REQ-035 N_SAMPLES=8, N_SETTLE=2, start, adf_done=1, fir_valid every 3rd cycle -> 2 strobes discarded, 8 fifo_wren, ramp_trig single pulse.
REQ-036 host_ready=1 -> fifo_rden 8 cycles, fft_en same 8 cycles shifted +1; fft_done -> chirp_cnt=1, back in CONFIG.
REQ-037 adf_done dropped after 4 captures -> lock_err=1, fifo_clr one pulse, CONFIG, chirp_cnt unchanged; next start clears lock_err.
REQ-038 stop asserted in CAPTURE -> chirp completes, chirp_cnt increments, IDLE, busy=0.
REQ-039 host_ready held 0 100 cycles in WAIT_HOST -> no fifo_rden; CNT_W=2 run 5 chirps -> chirp_cnt wraps to 1.
REQ-040 rst_n=0 mid-READ -> all outputs 0 next cycle, IDLE; start and stop same cycle in IDLE -> exactly one chirp.

Source files
------------

// File: rtl/fmcw_pkg.sv
// Shared types and defaults for the FMCW chirp sequencing logic.
package fmcw_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_CONFIG    = 3'd1,
    S_SETTLE    = 3'd2,
    S_CAPTURE   = 3'd3,
    S_WAIT_HOST = 3'd4,
    S_READ      = 3'd5,
    S_DRAIN     = 3'd6
  } state_t;

  localparam int DEF_N_SAMPLES = 1024;
  localparam int DEF_N_SETTLE  = 64;
  localparam int DEF_CNT_W     = 16;

  // One spare bit over the larger phase length so a phase never wraps.
  function automatic int seq_cnt_w(input int a, input int b);
    return $clog2((a > b) ? a : b) + 1;
  endfunction

endpackage

// File: rtl/seq_counter.sv
// Phase counter shared by SETTLE, CAPTURE and READ: clear, count, terminal flag.
module seq_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] last,
  output logic         tc
);

  logic [W-1:0] cnt;

  // Clear wins over count so the owner can restart a phase on the same edge it ends.
  always_ff @(posedge clk) begin
    if (!rst_n || clr) cnt <= '0;
    else if (en)       cnt <= cnt + 1'b1;
  end

  assign tc = (cnt == last);

endmodule

// File: rtl/sweep_sequencer.sv
// Chirp sequencer: configure synth, settle, capture to FIFO, hand frame to FFT.
module sweep_sequencer
  import fmcw_pkg::*;
#(
  parameter int N_SAMPLES = DEF_N_SAMPLES,
  parameter int N_SETTLE  = DEF_N_SETTLE,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             stop,
  input  logic             adf_done,
  input  logic             fir_valid,
  input  logic             host_ready,
  input  logic             fft_done,
  output logic             adf_en,
  output logic             fir_en,
  output logic             fifo_wren,
  output logic             fifo_rden,
  output logic             fft_en,
  output logic             ramp_trig,
  output logic             fifo_clr,
  output logic             busy,
  output logic             lock_err,
  output logic [CNT_W-1:0] chirp_cnt
);

  localparam int CW = seq_cnt_w(N_SAMPLES, N_SETTLE);
  localparam logic [CW-1:0] SAMP_LAST = CW'(N_SAMPLES - 1);
  localparam logic [CW-1:0] SETL_LAST = CW'((N_SETTLE > 0) ? N_SETTLE - 1 : 0);
  localparam state_t        CFG_NEXT  = (N_SETTLE == 0) ? S_CAPTURE : S_SETTLE;

  state_t           state;
  logic [CNT_W-1:0] chirp_q;
  logic             lock_err_q, stop_pending, ramp_q, clr_q, fft_en_q;
  logic             cnt_en, cnt_clr, cnt_tc, lock_lost, stop_any;
  logic [CW-1:0]    cnt_last;

  // Counter steering: which phase is counting, its terminal value, and when to restart.
  always_comb begin
    cnt_en    = 1'b0;
    cnt_last  = SAMP_LAST;
    lock_lost = 1'b0;
    cnt_clr   = 1'b1;
    case (state)
      S_SETTLE:  begin cnt_en = fir_valid; cnt_last = SETL_LAST; lock_lost = !adf_done; cnt_clr = 1'b0; end
      S_CAPTURE: begin cnt_en = fir_valid; lock_lost = !adf_done; cnt_clr = 1'b0; end
      S_READ:    begin cnt_en = 1'b1; cnt_clr = 1'b0; end
      default:   ;
    endcase
    if (lock_lost || (cnt_en && cnt_tc)) cnt_clr = 1'b1;
    stop_any = stop_pending || stop;
  end

  seq_counter #(.W(CW)) u_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (cnt_clr),
    .en    (cnt_en),
    .last  (cnt_last),
    .tc    (cnt_tc)
  );

  // Main sequencing FSM with registered pulses, sticky flags and the chirp count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      chirp_q      <= '0;
      lock_err_q   <= 1'b0;
      stop_pending <= 1'b0;
      ramp_q       <= 1'b0;
      clr_q        <= 1'b0;
      fft_en_q     <= 1'b0;
    end else begin
      ramp_q   <= 1'b0;
      clr_q    <= 1'b0;
      // FIFO read data appears one cycle after the read strobe.
      fft_en_q <= (state == S_READ);
      if (state != S_IDLE && stop) stop_pending <= 1'b1;
      case (state)
        S_IDLE: if (start) begin
          state        <= S_CONFIG;
          lock_err_q   <= 1'b0;
          stop_pending <= stop;
        end
        S_CONFIG: if (adf_done) begin
          ramp_q <= 1'b1;
          state  <= CFG_NEXT;
        end
        S_SETTLE, S_CAPTURE: begin
          if (lock_lost) begin
            // Lock lost mid-chirp: discard partial frame and retry (or quit).
            lock_err_q <= 1'b1;
            clr_q      <= 1'b1;
            if (stop_any) begin
              state        <= S_IDLE;
              stop_pending <= 1'b0;
            end else begin
              state <= S_CONFIG;
            end
          end else if (fir_valid && cnt_tc) begin
            state <= (state == S_SETTLE) ? S_CAPTURE : S_WAIT_HOST;
          end
        end
        S_WAIT_HOST: if (host_ready) state <= S_READ;
        S_READ:      if (cnt_tc) state <= S_DRAIN;
        S_DRAIN: if (fft_done) begin
          chirp_q <= chirp_q + 1'b1;
          if (stop_any) begin
            state        <= S_IDLE;
            stop_pending <= 1'b0;
          end else begin
            state <= S_CONFIG;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Output decode, held low while reset is asserted.
  always_comb begin
    adf_en    = rst_n && (state == S_CONFIG || state == S_SETTLE || state == S_CAPTURE);
    fir_en    = rst_n && (state == S_SETTLE || state == S_CAPTURE);
    fifo_wren = rst_n && (state == S_CAPTURE) && fir_valid;
    fifo_rden = rst_n && (state == S_READ);
    fft_en    = rst_n && fft_en_q;
    ramp_trig = rst_n && ramp_q;
    fifo_clr  = rst_n && clr_q;
    busy      = rst_n && (state != S_IDLE);
    lock_err  = rst_n && lock_err_q;
    chirp_cnt = rst_n ? chirp_q : '0;
  end

endmodule
